// File: rtl/eci_tx_vc_merge.sv
// eci_tx_vc_merge: round-robin merge of the rsp_wod, rsp_wd and fwd_wod ECI
// master channels into one TX packet stream. The output stage is a 2-entry
// skid buffer, so every ready_o is driven from a register and never sees
// tx_pkt_ready_i combinationally. Per-source packet counters are kept for link debug.
module eci_tx_vc_merge #(
  parameter int WORD_WIDTH = 64,
  parameter int PKT_WORDS  = 17,
  parameter int SIZE_WIDTH = 5,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                            eci_clk,
  input  logic                            eci_reset,
  // src 0: response without data (header only)
  input  logic [WORD_WIDTH-1:0]           rsp_wod_hdr_i,
  input  logic [SIZE_WIDTH-1:0]           rsp_wod_pkt_size_i,
  input  logic [3:0]                      rsp_wod_pkt_vc_i,
  input  logic                            rsp_wod_pkt_valid_i,
  output logic                            rsp_wod_pkt_ready_o,
  // src 1: response with data (full packet)
  input  logic [PKT_WORDS*WORD_WIDTH-1:0] rsp_wd_pkt_i,
  input  logic [SIZE_WIDTH-1:0]           rsp_wd_pkt_size_i,
  input  logic [3:0]                      rsp_wd_pkt_vc_i,
  input  logic                            rsp_wd_pkt_valid_i,
  output logic                            rsp_wd_pkt_ready_o,
  // src 2: forward without data (header only)
  input  logic [WORD_WIDTH-1:0]           fwd_wod_hdr_i,
  input  logic [SIZE_WIDTH-1:0]           fwd_wod_pkt_size_i,
  input  logic [3:0]                      fwd_wod_pkt_vc_i,
  input  logic                            fwd_wod_pkt_valid_i,
  output logic                            fwd_wod_pkt_ready_o,
  // merged stream
  output logic [PKT_WORDS*WORD_WIDTH-1:0] tx_pkt_o,
  output logic [SIZE_WIDTH-1:0]           tx_pkt_size_o,
  output logic [3:0]                      tx_pkt_vc_o,
  output logic [1:0]                      tx_pkt_src_o,
  output logic                            tx_pkt_valid_o,
  input  logic                            tx_pkt_ready_i,
  // debug
  output logic                            size_err_o,
  output logic [CNT_WIDTH-1:0]            cnt_rsp_wod_o,
  output logic [CNT_WIDTH-1:0]            cnt_rsp_wd_o,
  output logic [CNT_WIDTH-1:0]            cnt_fwd_wod_o
);

  localparam int PW = PKT_WORDS * WORD_WIDTH;
  localparam logic [SIZE_WIDTH-1:0] ONE_WORD = SIZE_WIDTH'(1);

  // Header-only packets carry the header in word 0 and zeros elsewhere.
  function automatic logic [PW-1:0] hdr_to_pkt(input logic [WORD_WIDTH-1:0] hdr);
    hdr_to_pkt = {{(PW-WORD_WIDTH){1'b0}}, hdr};
  endfunction

  // Round-robin successor over the three sources.
  function automatic logic [1:0] next_src(input logic [1:0] s);
    next_src = (s == 2'd2) ? 2'd0 : s + 2'd1;
  endfunction

  logic                  out_vld_q, out_vld_d;
  logic [PW-1:0]         out_pkt_q, out_pkt_d;
  logic [SIZE_WIDTH-1:0] out_size_q, out_size_d;
  logic [3:0]            out_vc_q, out_vc_d;
  logic [1:0]            out_src_q, out_src_d;
  logic                  skd_vld_q, skd_vld_d;
  logic [PW-1:0]         skd_pkt_q, skd_pkt_d;
  logic [SIZE_WIDTH-1:0] skd_size_q, skd_size_d;
  logic [3:0]            skd_vc_q, skd_vc_d;
  logic [1:0]            skd_src_q, skd_src_d;
  logic [1:0]            last_q, last_d;
  logic                  size_err_q, size_err_d;
  logic [CNT_WIDTH-1:0]  cnt0_q, cnt0_d, cnt1_q, cnt1_d, cnt2_q, cnt2_d;

  logic [2:0]            src_vld;
  logic [1:0]            cand0, cand1, cand2, win;
  logic                  win_found, can_acc, acc, out_hs;
  logic [PW-1:0]         new_pkt;
  logic [SIZE_WIDTH-1:0] new_size;
  logic [3:0]            new_vc;
  logic                  new_size_bad;

  // Arbitration: first valid source starting after the last grant wins.
  always_comb begin
    src_vld   = {fwd_wod_pkt_valid_i, rsp_wd_pkt_valid_i, rsp_wod_pkt_valid_i};
    cand0     = next_src(last_q);
    cand1     = next_src(cand0);
    cand2     = next_src(cand1);
    win       = cand0;
    win_found = 1'b0;
    if (src_vld[cand0]) begin
      win       = cand0;
      win_found = 1'b1;
    end else if (src_vld[cand1]) begin
      win       = cand1;
      win_found = 1'b1;
    end else if (src_vld[cand2]) begin
      win       = cand2;
      win_found = 1'b1;
    end
  end

  assign can_acc = !skd_vld_q;
  assign acc     = win_found && can_acc;
  assign out_hs  = out_vld_q && tx_pkt_ready_i;

  assign rsp_wod_pkt_ready_o = can_acc && win_found && (win == 2'd0);
  assign rsp_wd_pkt_ready_o  = can_acc && win_found && (win == 2'd1);
  assign fwd_wod_pkt_ready_o = can_acc && win_found && (win == 2'd2);

  // Format the winning source's packet; header-only sources are forced to one word.
  always_comb begin
    new_pkt      = '0;
    new_size     = ONE_WORD;
    new_vc       = '0;
    new_size_bad = 1'b0;
    case (win)
      2'd0: begin
        new_pkt      = hdr_to_pkt(rsp_wod_hdr_i);
        new_vc       = rsp_wod_pkt_vc_i;
        new_size_bad = (rsp_wod_pkt_size_i != ONE_WORD);
      end
      2'd1: begin
        new_pkt  = rsp_wd_pkt_i;
        new_size = rsp_wd_pkt_size_i;
        new_vc   = rsp_wd_pkt_vc_i;
      end
      default: begin
        new_pkt      = hdr_to_pkt(fwd_wod_hdr_i);
        new_vc       = fwd_wod_pkt_vc_i;
        new_size_bad = (fwd_wod_pkt_size_i != ONE_WORD);
      end
    endcase
  end

  // Skid buffer, grant pointer, error flag and counters next-state.
  always_comb begin
    out_vld_d  = out_vld_q;
    out_pkt_d  = out_pkt_q;
    out_size_d = out_size_q;
    out_vc_d   = out_vc_q;
    out_src_d  = out_src_q;
    skd_vld_d  = skd_vld_q;
    skd_pkt_d  = skd_pkt_q;
    skd_size_d = skd_size_q;
    skd_vc_d   = skd_vc_q;
    skd_src_d  = skd_src_q;
    if (out_hs && skd_vld_q) begin
      // Drain the skid entry into OUT; no accept is possible this cycle.
      out_pkt_d  = skd_pkt_q;
      out_size_d = skd_size_q;
      out_vc_d   = skd_vc_q;
      out_src_d  = skd_src_q;
      skd_vld_d  = 1'b0;
    end else if (acc) begin
      if (!out_vld_q || out_hs) begin
        out_vld_d  = 1'b1;
        out_pkt_d  = new_pkt;
        out_size_d = new_size;
        out_vc_d   = new_vc;
        out_src_d  = win;
      end else begin
        skd_vld_d  = 1'b1;
        skd_pkt_d  = new_pkt;
        skd_size_d = new_size;
        skd_vc_d   = new_vc;
        skd_src_d  = win;
      end
    end else if (out_hs) begin
      out_vld_d = 1'b0;
    end

    last_d     = acc ? win : last_q;
    size_err_d = size_err_q | (acc & new_size_bad);
    cnt0_d     = (acc && win == 2'd0) ? cnt0_q + CNT_WIDTH'(1) : cnt0_q;
    cnt1_d     = (acc && win == 2'd1) ? cnt1_q + CNT_WIDTH'(1) : cnt1_q;
    cnt2_d     = (acc && win == 2'd2) ? cnt2_q + CNT_WIDTH'(1) : cnt2_q;
  end

  // State registers; reset empties the buffer and points the arbiter at src 0.
  always_ff @(posedge eci_clk or posedge eci_reset) begin
    if (eci_reset) begin
      out_vld_q  <= 1'b0;
      out_pkt_q  <= '0;
      out_size_q <= '0;
      out_vc_q   <= '0;
      out_src_q  <= '0;
      skd_vld_q  <= 1'b0;
      skd_pkt_q  <= '0;
      skd_size_q <= '0;
      skd_vc_q   <= '0;
      skd_src_q  <= '0;
      last_q     <= 2'd2;
      size_err_q <= 1'b0;
      cnt0_q     <= '0;
      cnt1_q     <= '0;
      cnt2_q     <= '0;
    end else begin
      out_vld_q  <= out_vld_d;
      out_pkt_q  <= out_pkt_d;
      out_size_q <= out_size_d;
      out_vc_q   <= out_vc_d;
      out_src_q  <= out_src_d;
      skd_vld_q  <= skd_vld_d;
      skd_pkt_q  <= skd_pkt_d;
      skd_size_q <= skd_size_d;
      skd_vc_q   <= skd_vc_d;
      skd_src_q  <= skd_src_d;
      last_q     <= last_d;
      size_err_q <= size_err_d;
      cnt0_q     <= cnt0_d;
      cnt1_q     <= cnt1_d;
      cnt2_q     <= cnt2_d;
    end
  end

  assign tx_pkt_o       = out_pkt_q;
  assign tx_pkt_size_o  = out_size_q;
  assign tx_pkt_vc_o    = out_vc_q;
  assign tx_pkt_src_o   = out_src_q;
  assign tx_pkt_valid_o = out_vld_q;
  assign size_err_o     = size_err_q;
  assign cnt_rsp_wod_o  = cnt0_q;
  assign cnt_rsp_wd_o   = cnt1_q;
  assign cnt_fwd_wod_o  = cnt2_q;

endmodule

// File: tb/tb_eci_tx_vc_merge.sv
// Testbench for eci_tx_vc_merge: per-cycle vector table for arbitration and
// backpressure, scoreboard for packet contents, directed sequences for the
// header-only formatting, fairness, async reset and counter wrap (4-bit counters).
module tb_eci_tx_vc_merge;
  localparam int WW = 64;
  localparam int NW = 17;
  localparam int SW = 5;
  localparam int CW = 4;
  localparam int PW = WW * NW;

  logic          eci_clk = 1'b0;
  logic          eci_reset = 1'b1;
  logic [WW-1:0] rsp_wod_hdr_i, fwd_wod_hdr_i;
  logic [SW-1:0] rsp_wod_pkt_size_i, rsp_wd_pkt_size_i, fwd_wod_pkt_size_i;
  logic [3:0]    rsp_wod_pkt_vc_i, rsp_wd_pkt_vc_i, fwd_wod_pkt_vc_i;
  logic          rsp_wod_pkt_valid_i = 1'b0, rsp_wd_pkt_valid_i = 1'b0, fwd_wod_pkt_valid_i = 1'b0;
  logic          rsp_wod_pkt_ready_o, rsp_wd_pkt_ready_o, fwd_wod_pkt_ready_o;
  logic [PW-1:0] rsp_wd_pkt_i;
  logic [PW-1:0] tx_pkt_o;
  logic [SW-1:0] tx_pkt_size_o;
  logic [3:0]    tx_pkt_vc_o;
  logic [1:0]    tx_pkt_src_o;
  logic          tx_pkt_valid_o;
  logic          tx_pkt_ready_i = 1'b0;
  logic          size_err_o;
  logic [CW-1:0] cnt_rsp_wod_o, cnt_rsp_wd_o, cnt_fwd_wod_o;

  eci_tx_vc_merge #(.WORD_WIDTH(WW), .PKT_WORDS(NW), .SIZE_WIDTH(SW), .CNT_WIDTH(CW)) dut (
    .eci_clk(eci_clk), .eci_reset(eci_reset),
    .rsp_wod_hdr_i(rsp_wod_hdr_i), .rsp_wod_pkt_size_i(rsp_wod_pkt_size_i),
    .rsp_wod_pkt_vc_i(rsp_wod_pkt_vc_i), .rsp_wod_pkt_valid_i(rsp_wod_pkt_valid_i),
    .rsp_wod_pkt_ready_o(rsp_wod_pkt_ready_o),
    .rsp_wd_pkt_i(rsp_wd_pkt_i), .rsp_wd_pkt_size_i(rsp_wd_pkt_size_i),
    .rsp_wd_pkt_vc_i(rsp_wd_pkt_vc_i), .rsp_wd_pkt_valid_i(rsp_wd_pkt_valid_i),
    .rsp_wd_pkt_ready_o(rsp_wd_pkt_ready_o),
    .fwd_wod_hdr_i(fwd_wod_hdr_i), .fwd_wod_pkt_size_i(fwd_wod_pkt_size_i),
    .fwd_wod_pkt_vc_i(fwd_wod_pkt_vc_i), .fwd_wod_pkt_valid_i(fwd_wod_pkt_valid_i),
    .fwd_wod_pkt_ready_o(fwd_wod_pkt_ready_o),
    .tx_pkt_o(tx_pkt_o), .tx_pkt_size_o(tx_pkt_size_o), .tx_pkt_vc_o(tx_pkt_vc_o),
    .tx_pkt_src_o(tx_pkt_src_o), .tx_pkt_valid_o(tx_pkt_valid_o), .tx_pkt_ready_i(tx_pkt_ready_i),
    .size_err_o(size_err_o),
    .cnt_rsp_wod_o(cnt_rsp_wod_o), .cnt_rsp_wd_o(cnt_rsp_wd_o), .cnt_fwd_wod_o(cnt_fwd_wod_o)
  );

  always #5 eci_clk = ~eci_clk;

  typedef struct {
    logic [PW-1:0] pkt;
    logic [SW-1:0] size;
    logic [3:0]    vc;
    logic [1:0]    src;
  } exp_t;

  // One cycle of stimulus: valids {fwd,wd,wod}, tx ready, expected ready_o, expected tx valid.
  typedef struct {
    logic [2:0] v;
    logic       txr;
    logic [2:0] er;
    logic       etv;
  } vec_t;

  exp_t          exp_q[$];
  vec_t          tbl[15];
  int            n_chk = 0;
  int            n_pass = 0;
  int            seq[3];
  logic [CW-1:0] ecnt[3];
  logic          fixed_fwd = 1'b0;
  logic [WW-1:0] fhdr;
  logic [SW-1:0] fsz;
  logic [3:0]    fvc;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic logic [PW-1:0] hdr_only(input logic [WW-1:0] h);
    logic [PW-1:0] p;
    p = '0;
    p[WW-1:0] = h;
    return p;
  endfunction

  task automatic drive_data();
    rsp_wod_hdr_i      = {8'hA0, 24'(seq[0]), 32'h0000_1111};
    rsp_wod_pkt_size_i = 5'd1;
    rsp_wod_pkt_vc_i   = 4'(seq[0] + 1);
    for (int w = 0; w < NW; w++) rsp_wd_pkt_i[w*WW +: WW] = {8'hB1, 24'(seq[1]), 32'(w)};
    rsp_wd_pkt_size_i  = 5'(seq[1] % 17 + 1);
    rsp_wd_pkt_vc_i    = 4'(seq[1] + 3);
    if (!fixed_fwd) begin
      fhdr = {8'hC2, 24'(seq[2]), 32'h2222_0000};
      fsz  = 5'd1;
      fvc  = 4'(seq[2] + 7);
    end
    fwd_wod_hdr_i      = fhdr;
    fwd_wod_pkt_size_i = fsz;
    fwd_wod_pkt_vc_i   = fvc;
  endtask

  function automatic exp_t make_exp(input int s);
    exp_t e;
    e.src  = 2'(s);
    e.size = 5'd1;
    if (s == 0) begin
      e.pkt = hdr_only(rsp_wod_hdr_i);
      e.vc  = rsp_wod_pkt_vc_i;
    end else if (s == 1) begin
      e.pkt  = rsp_wd_pkt_i;
      e.size = rsp_wd_pkt_size_i;
      e.vc   = rsp_wd_pkt_vc_i;
    end else begin
      e.pkt = hdr_only(fwd_wod_hdr_i);
      e.vc  = fwd_wod_pkt_vc_i;
    end
    return e;
  endfunction

  // Apply one cycle, check ready/valid, score any output handshake, push expected accepts.
  task automatic step(input logic [2:0] v, input logic txr, input logic [2:0] er, input logic etv);
    exp_t e;
    logic [2:0] accd;
    {fwd_wod_pkt_valid_i, rsp_wd_pkt_valid_i, rsp_wod_pkt_valid_i} = v;
    tx_pkt_ready_i = txr;
    #2;
    chk("ready_o", 64'({fwd_wod_pkt_ready_o, rsp_wd_pkt_ready_o, rsp_wod_pkt_ready_o}), 64'(er));
    chk("tx_valid", 64'(tx_pkt_valid_o), 64'(etv));
    if (tx_pkt_valid_o && txr) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        $display("FAIL sb_underflow: unexpected packet src=%0d word0=%h", tx_pkt_src_o, tx_pkt_o[63:0]);
      end else begin
        e = exp_q.pop_front();
        chk("pkt_word0", tx_pkt_o[63:0], e.pkt[63:0]);
        chk("pkt_upper_diff", 64'(|(tx_pkt_o ^ e.pkt)), 64'd0);
        chk("pkt_size", 64'(tx_pkt_size_o), 64'(e.size));
        chk("pkt_vc", 64'(tx_pkt_vc_o), 64'(e.vc));
        chk("pkt_src", 64'(tx_pkt_src_o), 64'(e.src));
      end
    end
    accd = er & v;
    for (int i = 0; i < 3; i++) begin
      if (accd[i]) begin
        exp_q.push_back(make_exp(i));
        ecnt[i] = ecnt[i] + 1'b1;
      end
    end
    @(posedge eci_clk);
    #1;
    for (int i = 0; i < 3; i++) if (accd[i]) seq[i]++;
    drive_data();
  endtask

  task automatic chk_cnts();
    chk("cnt_rsp_wod", 64'(cnt_rsp_wod_o), 64'(ecnt[0]));
    chk("cnt_rsp_wd", 64'(cnt_rsp_wd_o), 64'(ecnt[1]));
    chk("cnt_fwd_wod", 64'(cnt_fwd_wod_o), 64'(ecnt[2]));
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      seq[i]  = i * 16;
      ecnt[i] = '0;
    end
    drive_data();
    // All three valid, output always ready: strict 0,1,2 rotation, one packet per cycle.
    tbl[0]  = '{3'b111, 1'b1, 3'b001, 1'b0};
    tbl[1]  = '{3'b111, 1'b1, 3'b010, 1'b1};
    tbl[2]  = '{3'b111, 1'b1, 3'b100, 1'b1};
    tbl[3]  = '{3'b111, 1'b1, 3'b001, 1'b1};
    tbl[4]  = '{3'b111, 1'b1, 3'b010, 1'b1};
    tbl[5]  = '{3'b111, 1'b1, 3'b100, 1'b1};
    tbl[6]  = '{3'b000, 1'b1, 3'b000, 1'b1};
    tbl[7]  = '{3'b000, 1'b1, 3'b000, 1'b0};
    // rsp_wd only with output stalled: OUT then SKD fill, then ready_o drops.
    tbl[8]  = '{3'b010, 1'b0, 3'b010, 1'b0};
    tbl[9]  = '{3'b010, 1'b0, 3'b010, 1'b1};
    tbl[10] = '{3'b010, 1'b0, 3'b000, 1'b1};
    tbl[11] = '{3'b010, 1'b1, 3'b000, 1'b1};
    tbl[12] = '{3'b010, 1'b1, 3'b010, 1'b1};
    tbl[13] = '{3'b000, 1'b1, 3'b000, 1'b1};
    tbl[14] = '{3'b000, 1'b1, 3'b000, 1'b0};

    // Reset state
    repeat (3) @(posedge eci_clk);
    #1;
    chk("rst_tx_valid", 64'(tx_pkt_valid_o), 64'd0);
    chk("rst_tx_word0", tx_pkt_o[63:0], 64'd0);
    chk("rst_size_err", 64'(size_err_o), 64'd0);
    chk_cnts();
    eci_reset = 1'b0;

    for (int i = 0; i < 15; i++) step(tbl[i].v, tbl[i].txr, tbl[i].er, tbl[i].etv);
    chk_cnts();
    chk("size_err_clean", 64'(size_err_o), 64'd0);

    // fwd_wod with bad size: forwarded as one word, error latches.
    fixed_fwd = 1'b1;
    fhdr = 64'hDEAD_BEEF;
    fsz  = 5'd3;
    fvc  = 4'd5;
    drive_data();
    step(3'b100, 1'b1, 3'b100, 1'b0);
    chk("size_err_set", 64'(size_err_o), 64'd1);
    step(3'b000, 1'b1, 3'b000, 1'b1);
    step(3'b000, 1'b1, 3'b000, 1'b0);
    fixed_fwd = 1'b0;
    drive_data();
    chk("size_err_sticky", 64'(size_err_o), 64'd1);

    // rsp_wod held valid, fwd arrives: fwd served on the next grant.
    step(3'b101, 1'b1, 3'b001, 1'b0);
    step(3'b101, 1'b1, 3'b100, 1'b1);
    step(3'b001, 1'b1, 3'b001, 1'b1);
    step(3'b000, 1'b1, 3'b000, 1'b1);
    step(3'b000, 1'b1, 3'b000, 1'b0);
    chk("size_err_still", 64'(size_err_o), 64'd1);
    chk_cnts();

    // Fill OUT and SKD, then assert reset mid-cycle.
    step(3'b010, 1'b0, 3'b010, 1'b0);
    step(3'b010, 1'b0, 3'b010, 1'b1);
    {fwd_wod_pkt_valid_i, rsp_wd_pkt_valid_i, rsp_wod_pkt_valid_i} = 3'b000;
    #1;
    eci_reset = 1'b1;
    #1;
    chk("async_rst_valid", 64'(tx_pkt_valid_o), 64'd0);
    chk("async_rst_word0", tx_pkt_o[63:0], 64'd0);
    chk("async_rst_size_err", 64'(size_err_o), 64'd0);
    exp_q.delete();
    for (int i = 0; i < 3; i++) ecnt[i] = '0;
    chk_cnts();
    @(posedge eci_clk);
    @(posedge eci_clk);
    #1;
    eci_reset = 1'b0;
    step(3'b111, 1'b1, 3'b001, 1'b0);
    step(3'b000, 1'b1, 3'b000, 1'b1);

    // 2^4+3 rsp_wod packets in total since reset: counter wraps to 3.
    for (int k = 0; k < 18; k++) step(3'b001, 1'b1, 3'b001, (k != 0));
    step(3'b000, 1'b1, 3'b000, 1'b1);
    step(3'b000, 1'b1, 3'b000, 1'b0);
    chk_cnts();
    chk("cnt_wrap", 64'(cnt_rsp_wod_o), 64'd3);
    chk("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
